// File: rtl/kitchen_timer_pkg.sv
// Shared types and constants for the kitchen timer: FSM states, BCD digit limits
// and the single-action-per-cycle input arbitration.
package kitchen_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_CLEAR,
        ACT_START,
        ACT_MIN,
        ACT_SEC,
        ACT_TICK
    } action_t;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] UNITS_MAX    = 4'd9;

    // The highest-priority asserted input is the only one acted on this cycle,
    // even if the current state ignores it.
    function automatic action_t pick_action(input logic clear, input logic start,
                                            input logic min, input logic sec,
                                            input logic tick);
        if (clear)      return ACT_CLEAR;
        else if (start) return ACT_START;
        else if (min)   return ACT_MIN;
        else if (sec)   return ACT_SEC;
        else if (tick)  return ACT_TICK;
        else            return ACT_NONE;
    endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// Four-digit MM:SS BCD register with increment, borrow-chain decrement and clear.
// Any non-BCD digit pattern is forced back to 00:00 on the next clock.
module bcd_mmss_counter
    import kitchen_timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       inc_min,
    input  logic       inc_sec,
    input  logic       dec,
    output logic [3:0] bin3,
    output logic [3:0] bin2,
    output logic [3:0] bin1,
    output logic [3:0] bin0,
    output logic       zero,
    output logic       one
);

    logic [3:0] n3, n2, n1, n0;
    logic       legal;

    assign legal = (bin3 <= SEC_TENS_MAX) && (bin2 <= UNITS_MAX) &&
                   (bin1 <= SEC_TENS_MAX) && (bin0 <= UNITS_MAX);
    assign zero  = ({bin3, bin2, bin1, bin0} == 16'h0000);
    assign one   = ({bin3, bin2, bin1, bin0} == 16'h0001);

    // NOTE: every combinational output is given a default first so no path can infer a latch.
    always_comb begin
        n3 = bin3;
        n2 = bin2;
        n1 = bin1;
        n0 = bin0;
        if (clr || !legal) begin
            n3 = 4'd0;
            n2 = 4'd0;
            n1 = 4'd0;
            n0 = 4'd0;
        end else if (inc_min) begin
            if (bin2 == UNITS_MAX) begin
                n2 = 4'd0;
                n3 = (bin3 == SEC_TENS_MAX) ? 4'd0 : bin3 + 4'd1;
            end else begin
                n2 = bin2 + 4'd1;
            end
        end else if (inc_sec) begin
            if (bin0 == UNITS_MAX) begin
                n0 = 4'd0;
                n1 = (bin1 == SEC_TENS_MAX) ? 4'd0 : bin1 + 4'd1;
            end else begin
                n0 = bin0 + 4'd1;
            end
        end else if (dec && !zero) begin
            if (bin0 != 4'd0) begin
                n0 = bin0 - 4'd1;
            end else begin
                n0 = UNITS_MAX;
                if (bin1 != 4'd0) begin
                    n1 = bin1 - 4'd1;
                end else begin
                    n1 = SEC_TENS_MAX;
                    if (bin2 != 4'd0) begin
                        n2 = bin2 - 4'd1;
                    end else begin
                        n2 = UNITS_MAX;
                        n3 = bin3 - 4'd1;
                    end
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin3 <= 4'd0;
            bin2 <= 4'd0;
            bin1 <= 4'd0;
            bin0 <= 4'd0;
        end else begin
            bin3 <= n3;
            bin2 <= n2;
            bin1 <= n1;
            bin0 <= n0;
        end
    end

endmodule

// File: rtl/kitchen_timer_ctrl.sv
// Kitchen timer control FSM: set, start/pause, clear and alarm handling around
// the MM:SS BCD counter, with registered status and display-blink outputs.
module kitchen_timer_ctrl
    import kitchen_timer_pkg::*;
#(
    parameter int unsigned ALARM_SECS = 30,
    parameter bit          BLINK_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       btn_min,
    input  logic       btn_sec,
    input  logic       btn_start,
    input  logic       btn_clear,
    output logic [3:0] bin3,
    output logic [3:0] bin2,
    output logic [3:0] bin1,
    output logic [3:0] bin0,
    output logic       running,
    output logic       alarm,
    output logic       done,
    output logic       blink
);

    localparam logic [7:0] ALARM_LIM = 8'(ALARM_SECS);

    state_t     state, state_nxt;
    action_t    act;
    logic [7:0] acnt, acnt_nxt;
    logic       blink_nxt;
    logic       clr, inc_min, inc_sec, dec;
    logic       is_zero, is_one;

    assign act = pick_action(btn_clear, btn_start, btn_min, btn_sec, tick);

    bcd_mmss_counter u_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .inc_min (inc_min),
        .inc_sec (inc_sec),
        .dec     (dec),
        .bin3    (bin3),
        .bin2    (bin2),
        .bin1    (bin1),
        .bin0    (bin0),
        .zero    (is_zero),
        .one     (is_one)
    );

    always_comb begin
        state_nxt = state;
        acnt_nxt  = acnt;
        blink_nxt = blink;
        clr       = 1'b0;
        inc_min   = 1'b0;
        inc_sec   = 1'b0;
        dec       = 1'b0;
        case (state)
            ST_IDLE: begin
                blink_nxt = 1'b0;
                acnt_nxt  = 8'd0;
                case (act)
                    ACT_CLEAR: clr = 1'b1;
                    ACT_START: if (!is_zero) state_nxt = ST_RUN;
                    ACT_MIN:   inc_min = 1'b1;
                    ACT_SEC:   inc_sec = 1'b1;
                    default:   ;
                endcase
            end
            ST_RUN: begin
                blink_nxt = 1'b0;
                case (act)
                    ACT_CLEAR: begin
                        clr       = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                    ACT_START: begin
                        state_nxt = ST_PAUSE;
                        blink_nxt = BLINK_EN;
                    end
                    ACT_TICK: begin
                        dec = 1'b1;
                        // 00:01 -> 00:00 lands in ALARM on the same edge as the digit update.
                        if (is_one || is_zero) begin
                            state_nxt = ST_ALARM;
                            blink_nxt = BLINK_EN;
                            acnt_nxt  = 8'd0;
                        end
                    end
                    default: ;
                endcase
            end
            ST_PAUSE: begin
                case (act)
                    ACT_CLEAR: begin
                        clr       = 1'b1;
                        state_nxt = ST_IDLE;
                        blink_nxt = 1'b0;
                    end
                    ACT_START: begin
                        state_nxt = ST_RUN;
                        blink_nxt = 1'b0;
                    end
                    ACT_TICK: blink_nxt = BLINK_EN ? ~blink : 1'b0;
                    default:  ;
                endcase
            end
            ST_ALARM: begin
                case (act)
                    ACT_NONE: ;
                    ACT_TICK: begin
                        if (acnt + 8'd1 >= ALARM_LIM) begin
                            state_nxt = ST_IDLE;
                            acnt_nxt  = 8'd0;
                            blink_nxt = 1'b0;
                        end else begin
                            acnt_nxt  = acnt + 8'd1;
                            blink_nxt = BLINK_EN ? ~blink : 1'b0;
                        end
                    end
                    default: begin
                        clr       = 1'b1;
                        state_nxt = ST_IDLE;
                        acnt_nxt  = 8'd0;
                        blink_nxt = 1'b0;
                    end
                endcase
            end
            default: begin
                clr       = 1'b1;
                state_nxt = ST_IDLE;
                acnt_nxt  = 8'd0;
                blink_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            acnt    <= 8'd0;
            blink   <= 1'b0;
            running <= 1'b0;
            alarm   <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            acnt    <= acnt_nxt;
            blink   <= blink_nxt;
            running <= (state_nxt == ST_RUN);
            alarm   <= (state_nxt == ST_ALARM);
            done    <= (state_nxt == ST_ALARM) && (state != ST_ALARM);
        end
    end

endmodule
